// File: rtl/router_out_arbiter_if.sv
// rtl/router_out_arbiter_if.sv - handshake bundle between input ports, output arbiter and link
// Purpose: groups the request/grant/flow-control signals of one router output.
// Signals:
//   req_i       [NIN]   per-input flit valid toward this output
//   tail_i      [NIN]   per-input last-flit-of-packet flag
//   out_ready_i         downstream link can accept a flit
//   gnt_o       [NIN]   one-hot owner of the output, zero when unowned
//   sel_o       [SELW]  binary owner index for the output mux
//   out_valid_o         muxed flit is valid
//   in_ready_o  [NIN]   per-input pop strobe
//   busy_o              output locked to a packet
// Modports: slave = arbiter side, master = requester/link side.
interface router_out_arbiter_if #(
  parameter int NIN  = 4,
  parameter int SELW = $clog2(NIN)
);
  logic [NIN-1:0]  req_i;
  logic [NIN-1:0]  tail_i;
  logic            out_ready_i;
  logic [NIN-1:0]  gnt_o;
  logic [SELW-1:0] sel_o;
  logic            out_valid_o;
  logic [NIN-1:0]  in_ready_o;
  logic            busy_o;

  modport slave (
    input  req_i, tail_i, out_ready_i,
    output gnt_o, sel_o, out_valid_o, in_ready_o, busy_o
  );

  modport master (
    output req_i, tail_i, out_ready_i,
    input  gnt_o, sel_o, out_valid_o, in_ready_o, busy_o
  );
endinterface

// File: rtl/router_out_arbiter.sv
// rtl/router_out_arbiter.sv - round-robin wormhole switch allocator for one router output
// Purpose: grants the output to one input for a whole packet, rotating priority
// after every completed packet, and gates flit transfer with valid/ready.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    router_out_arbiter_if.slave (req/tail/out_ready in; gnt/sel/out_valid/in_ready/busy out)
module router_out_arbiter #(
  parameter int NIN = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  router_out_arbiter_if.slave   bus
);
  localparam int SELW = $clog2(NIN);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [NIN-1:0]  gnt_q, gnt_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;

  logic            found;
  logic [SELW-1:0] pick;
  logic [SELW-1:0] idx;
  logic            own_req;
  logic            own_tail;
  logic            out_valid;
  logic [NIN-1:0]  in_ready;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    out_valid = 1'b0;
    in_ready  = '0;
    found     = 1'b0;
    pick      = '0;
    idx       = '0;

    // Rotating scan starting at the priority pointer; first hit wins.
    for (int i = 0; i < NIN; i++) begin
      idx = SELW'((int'(ptr_q) + i) % NIN);
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    // gnt_q is zero in IDLE, so these only see the owner while LOCKED.
    own_req  = |(bus.req_i & gnt_q);
    own_tail = |(bus.tail_i & gnt_q);

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = LOCKED;
          gnt_d   = NIN'(1) << pick;
          sel_d   = pick;
        end
      end
      LOCKED: begin
        out_valid = own_req;
        in_ready  = gnt_q & bus.req_i & {NIN{bus.out_ready_i}};
        // Lock is released only by a tail flit actually leaving; sel_q keeps
        // its value so the mux select does not glitch during the idle bubble.
        if (own_req && bus.out_ready_i && own_tail) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = SELW'((int'(sel_q) + 1) % NIN);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.sel_o       = sel_q;
  assign bus.busy_o      = (state_q == LOCKED);
  assign bus.out_valid_o = out_valid;
  assign bus.in_ready_o  = in_ready;
endmodule

// File: tb/tb_router_out_arbiter.sv
// tb/tb_router_out_arbiter.sv - self-checking bench for router_out_arbiter
module tb_router_out_arbiter;
  localparam int NIN = 4;

  logic clk;
  logic rst;

  router_out_arbiter_if #(.NIN(NIN)) bus ();

  router_out_arbiter #(.NIN(NIN)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: owner index (-1 = output free), priority pointer, last select.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;

  logic           prev_ok   = 1'b0;
  logic           prev_busy = 1'b0;
  logic [NIN-1:0] prev_gnt  = '0;
  logic           prev_tx_tail = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs mid-cycle, compare against the model,
  // then advance the model to what the next rising edge should produce.
  task automatic step(input logic r, input logic [NIN-1:0] rq,
                      input logic [NIN-1:0] tl, input logic ordy);
    logic [NIN-1:0] e_gnt;
    logic [NIN-1:0] e_rdy;
    logic           e_val;
    logic           found;
    int             k;
    @(negedge clk);
    rst             = r;
    bus.req_i       = rq;
    bus.tail_i      = tl;
    bus.out_ready_i = ordy;
    #1;

    e_gnt = (m_owner < 0) ? '0 : (NIN'(1) << m_owner);
    e_val = (m_owner >= 0) && rq[m_owner];
    e_rdy = (e_val && ordy) ? e_gnt : '0;

    check("gnt",       32'(bus.gnt_o),       32'(e_gnt));
    check("sel",       32'(bus.sel_o),       32'(m_sel));
    check("busy",      32'(bus.busy_o),      32'(m_owner >= 0));
    check("out_valid", 32'(bus.out_valid_o), 32'(e_val));
    check("in_ready",  32'(bus.in_ready_o),  32'(e_rdy));

    check("inv_onehot0",  32'($onehot0(bus.gnt_o)), 32'(1));
    check("inv_busy_gnt", 32'(bus.busy_o), 32'(|bus.gnt_o));
    check("inv_rdy_subset", 32'(bus.in_ready_o & ~bus.gnt_o), 32'(0));
    if (prev_ok && prev_busy && !prev_tx_tail)
      check("inv_gnt_stable", 32'(bus.gnt_o), 32'(prev_gnt));

    prev_ok      = !r;
    prev_busy    = bus.busy_o;
    prev_gnt     = bus.gnt_o;
    prev_tx_tail = |(bus.in_ready_o & tl);

    if (r) begin
      m_owner = -1;
      m_ptr   = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 0; i < NIN; i++) begin
        k = (m_ptr + i) % NIN;
        if (!found && rq[k]) begin
          found   = 1'b1;
          m_owner = k;
          m_sel   = k;
        end
      end
    end else if (rq[m_owner] && ordy && tl[m_owner]) begin
      m_ptr   = (m_owner + 1) % NIN;
      m_owner = -1;
    end
  endtask

  int rr_got[$];
  int rr_exp[5] = '{0, 1, 2, 3, 0};
  logic was_busy;

  initial begin
    rst             = 1'b1;
    bus.req_i       = '0;
    bus.tail_i      = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held with every input requesting.
    step(1'b1, 4'b1111, 4'b0000, 1'b1);
    step(1'b1, 4'b1111, 4'b0000, 1'b1);

    // Round-robin of single-flit packets; grants land every other cycle.
    was_busy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 4'b1111, 4'b1111, 1'b1);
      if (bus.busy_o && !was_busy) rr_got.push_back(int'(bus.sel_o));
      was_busy = bus.busy_o;
    end
    check("rr_count", 32'(rr_got.size()), 32'(5));
    for (int i = 0; i < 5; i++)
      if (i < rr_got.size()) check("rr_order", 32'(rr_got[i]), 32'(rr_exp[i]));

    // Wormhole lock: input 2 sends 3 flits while input 1 keeps requesting.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0110, 4'b0000, 1'b1);
    step(1'b0, 4'b0110, 4'b0000, 1'b1);
    step(1'b0, 4'b0110, 4'b0100, 1'b1);
    step(1'b0, 4'b0010, 4'b0000, 1'b1);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    check("wormhole_next_owner_done", 32'(bus.busy_o), 32'(1));

    // Backpressure on a tail flit from input 1.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 4'b0010, 4'b0010, 1'b0);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    check("bp_in_ready", 32'(bus.in_ready_o), 32'(4'b0010));
    step(1'b0, 4'b0000, 4'b0000, 1'b1);

    // Input bubble: owner 3 stalls while input 0 requests.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b1000, 4'b0000, 1'b1);
    step(1'b0, 4'b1001, 4'b0000, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    check("bubble_gnt", 32'(bus.gnt_o), 32'(4'b1000));
    step(1'b0, 4'b1001, 4'b1000, 1'b1);
    step(1'b0, 4'b0001, 4'b0000, 1'b1);
    step(1'b0, 4'b0001, 4'b0001, 1'b1);

    // Reset in the middle of a 4-flit packet from input 2.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b0100, 4'b0000, 1'b1);
    step(1'b0, 4'b0101, 4'b0000, 1'b1);
    step(1'b1, 4'b0101, 4'b0000, 1'b1);
    step(1'b0, 4'b0101, 4'b0000, 1'b1);
    step(1'b0, 4'b0101, 4'b0001, 1'b1);
    check("post_reset_owner", 32'(bus.sel_o), 32'(0));

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      step(($urandom_range(0, 99) == 0),
           NIN'($urandom_range(0, 15)),
           NIN'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port switch allocator for the mesh router.
- Route computation at each input port decodes dst_x/dst_y into a direction select. Every input whose current flit targets this output raises a request here.
- The block grants the output to one input for a whole packet (wormhole lock) using round-robin priority. It sequences flit transfer with a valid/ready handshake toward the downstream link.
- One instance sits in front of each output mux (N/S/E/W/local/diagonal as present for the router type).

Parameters:
- NIN, 4, number of requesting input ports (legal 2..8).
- SELW, $clog2(NIN), width of the mux select output (derived; not overridden).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  NIN  per-input flit valid toward this output (from route computation).
- tail_i  input  NIN  per-input flag marking the current flit as the last flit of its packet.
- out_ready_i  input  1  downstream can accept a flit this cycle.
- gnt_o  output  NIN  one-hot owner of the output; all-zero when unowned.
- sel_o  output  SELW  binary index of the owner; drives the output mux select.
- out_valid_o  output  1  flit on the muxed datapath is valid.
- in_ready_o  output  NIN  per-input pop/accept strobe.
- busy_o  output  1  output is locked to a packet.

Behaviour:
- Reset (rst_i=1 at a clock edge): state=IDLE, gnt_o=0, sel_o=0, busy_o=0, priority pointer ptr=0. out_valid_o=0 and in_ready_o=0 follow combinationally. Reset wins over every other event, including mid-packet; any lock is dropped.
- State machine has two states, IDLE and LOCKED.
- IDLE:
  - gnt_o=0, out_valid_o=0, in_ready_o=0.
  - If any req_i bit is set, pick the first set bit scanning ptr, ptr+1, ..., NIN-1, 0, ..., ptr-1 (mod NIN).
  - Register that input as owner: gnt_o one-hot, sel_o=index, busy_o=1. State becomes LOCKED next cycle.
  - Arbitration latency is 1 cycle: a request at edge t is granted from edge t+1.
- LOCKED (owner k):
  - gnt_o and sel_o are held constant.
  - out_valid_o = req_i[k].
  - in_ready_o[k] = req_i[k] & out_ready_i; all other in_ready_o bits are 0.
  - Transfer occurs when out_valid_o & out_ready_i.
  - Transfer with tail_i[k]=1: next state IDLE, gnt_o=0, busy_o=0, ptr=(k+1) mod NIN. sel_o keeps its last value.
  - Transfer without tail: remain LOCKED.
  - Owner deasserts req_i[k] mid-packet (input bubble): remain LOCKED, out_valid_o=0, no other input is granted.
  - Requests from non-owners are ignored while LOCKED.
- Single-flit packets (head = tail) lock for exactly one transfer.
- After each packet there is one mandatory IDLE bubble cycle before the next grant. Maximum link throughput for back-to-back single-flit packets is therefore 1 flit / 2 cycles.
- Fairness: ptr advances only on packet completion. No input waits more than NIN-1 packets once requesting.
- out_valid_o and in_ready_o are combinational from registered state plus req_i/out_ready_i. There is no combinational path from out_ready_i to gnt_o or sel_o.
- tail_i of non-owners and tail_i of the owner without transfer have no effect.
- Invariants (assert in bench):
  - gnt_o is onehot0.
  - busy_o == |gnt_o.
  - in_ready_o is a subset of gnt_o.
  - gnt_o is stable while busy_o=1 and no tail transfer occurs.

Test Plan:
- Reset: hold rst_i 2 cycles with req_i=4'b1111 -> gnt_o=0, sel_o=0, busy_o=0, out_valid_o=0 throughout. First grant after release goes to input 0.
- Round-robin: req_i=4'b1111 held, each flit tail=1, out_ready_i=1 -> grant order 0,1,2,3,0. Transfers occur on every other cycle.
- Wormhole lock: input 2 sends a 3-flit packet (tail on flit 3) while input 1 requests continuously -> gnt_o=4'b0100 for all 3 transfers. Input 1 is granted one cycle after the tail transfer.
- Backpressure: locked to input 1, out_ready_i=0 for 5 cycles -> out_valid_o=1, in_ready_o=0, grant held. out_ready_i=1 on a tail flit -> in_ready_o=4'b0010 for one cycle, then IDLE.
- Input bubble: owner 3 drops req_i[3] for 2 cycles mid-packet while input 0 requests -> out_valid_o=0, gnt_o stays 4'b1000, input 0 is not granted.
- Reset mid-packet: rst_i pulsed while locked to input 2 after 1 of 4 flits -> gnt_o=0 and ptr=0 next cycle. Input 0 (requesting) is granted first afterward.
